// File: rtl/parity_pkg.sv
// parity_pkg: shared types and constants for the serial parity generator/checker.
//   parity_state_t : FSM state encoding (IDLE, ACCUM, CHECK)
//   PAR_EVEN/PAR_ODD : values of odd_sel
//   MODE_GEN/MODE_CHK: values of chk_en
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CHECK = 2'd2
    } parity_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears q
//   inc : increment request for this cycle
//   q   : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/parity_gen_n.sv
// parity_gen_n: serial parity generator/checker over groups of GROUP_LEN bits.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   w_valid, w : serial bit stream; a bit is consumed on every clk edge with
//                w_valid=1. There is no backpressure: the block always accepts.
//   odd_sel    : 0 even / 1 odd parity, sampled with the first bit of a group
//   chk_en     : 0 generate / 1 check, sampled with the first bit of a group;
//                in check mode one extra received parity bit follows the data
//   z, err     : parity and mismatch flag of the last completed group (held)
//   z_valid    : one-cycle pulse when z/err update
//   err_cnt    : saturating mismatch count, cleared only by reset
//   busy       : a group is in progress
//   dbg_state  : current FSM state
module parity_gen_n
    import parity_pkg::*;
#(
    parameter int GROUP_LEN = 3,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_valid,
    input  logic             w,
    input  logic             odd_sel,
    input  logic             chk_en,
    output logic             z,
    output logic             z_valid,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy,
    output parity_state_t    dbg_state
);

    localparam int CW = $clog2(GROUP_LEN + 1);
    // cnt value seen in ACCUM when the incoming bit is the last data bit
    localparam logic [CW-1:0] LAST = CW'(GROUP_LEN - 1);

    parity_state_t state, state_d;
    logic          acc, acc_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          odd_l, odd_d;
    logic          chk_l, chk_d;
    logic          par_l, par_d;   // computed parity waiting for the received bit
    logic          z_d, err_d, zv_d;
    logic          inc_err;
    logic          done;           // last data bit consumed this cycle
    logic          par_new;        // parity of the group completing this cycle
    logic          chk_cur;        // mode of the group completing this cycle

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= 1'b0;
            cnt     <= '0;
            odd_l   <= 1'b0;
            chk_l   <= 1'b0;
            par_l   <= 1'b0;
            z       <= 1'b0;
            err     <= 1'b0;
            z_valid <= 1'b0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            cnt     <= cnt_d;
            odd_l   <= odd_d;
            chk_l   <= chk_d;
            par_l   <= par_d;
            z       <= z_d;
            err     <= err_d;
            z_valid <= zv_d;
        end
    end

    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        odd_d   = odd_l;
        chk_d   = chk_l;
        par_d   = par_l;
        z_d     = z;
        err_d   = err;
        zv_d    = 1'b0;
        inc_err = 1'b0;
        done    = 1'b0;
        par_new = 1'b0;
        chk_cur = chk_l;

        if (w_valid) begin
            case (state)
                IDLE: begin
                    // First bit of a group: the mode is taken from the live
                    // inputs because the latches only update at this edge.
                    odd_d   = odd_sel;
                    chk_d   = chk_en;
                    acc_d   = w;
                    cnt_d   = CW'(1);
                    par_new = w ^ (odd_sel == PAR_ODD);
                    chk_cur = chk_en;
                    done    = (GROUP_LEN == 1);
                    if (GROUP_LEN != 1) begin
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_d   = acc ^ w;
                    cnt_d   = cnt + 1'b1;
                    par_new = acc ^ w ^ (odd_l == PAR_ODD);
                    chk_cur = chk_l;
                    done    = (cnt == LAST);
                end
                CHECK: begin
                    z_d     = par_l;
                    err_d   = (w != par_l);
                    zv_d    = 1'b1;
                    inc_err = (w != par_l);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (done) begin
                if (chk_cur == MODE_CHK) begin
                    par_d   = par_new;
                    state_d = CHECK;
                end else begin
                    z_d     = par_new;
                    err_d   = 1'b0;
                    zv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_err),
        .q   (err_cnt)
    );

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_parity_gen_n.sv
module tb_parity_gen_n;
    import parity_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic w_valid, w, odd_sel, chk_en;

    // instance 0: GROUP_LEN=3, ERR_W=2 ; instance 1: GROUP_LEN=1, ERR_W=4
    logic          z3, zv3, err3, busy3;
    logic [1:0]    ec3;
    parity_state_t st3;
    logic          z1, zv1, err1, busy1;
    logic [3:0]    ec1;
    parity_state_t st1;

    parity_gen_n #(.GROUP_LEN(3), .ERR_W(2)) dut3 (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w(w), .odd_sel(odd_sel),
        .chk_en(chk_en), .z(z3), .z_valid(zv3), .err(err3), .err_cnt(ec3),
        .busy(busy3), .dbg_state(st3)
    );

    parity_gen_n #(.GROUP_LEN(1), .ERR_W(4)) dut1 (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w(w), .odd_sel(odd_sel),
        .chk_en(chk_en), .z(z1), .z_valid(zv1), .err(err1), .err_cnt(ec1),
        .busy(busy1), .dbg_state(st1)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Group-level view: collect bits, count ones, decide when the group ends.
    int   gl[2]   = '{3, 1};
    int   cmax[2] = '{3, 15};
    int   n[2], ones[2], ecnt[2];
    bit   odd_m[2], chk_m[2];
    logic ez[2], ezv[2], eerr[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            n[i] = 0; ones[i] = 0; ecnt[i] = 0;
            odd_m[i] = 0; chk_m[i] = 0;
            ez[i] = 0; ezv[i] = 0; eerr[i] = 0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int p;
            ezv[i] = 1'b0;
            if (w_valid) begin
                if (n[i] == 0) begin
                    odd_m[i] = odd_sel;
                    chk_m[i] = chk_en;
                    ones[i]  = 0;
                end
                n[i]++;
                if (n[i] <= gl[i]) ones[i] += int'(w);
                p = (ones[i] % 2) ^ int'(odd_m[i]);
                if (!chk_m[i] && n[i] == gl[i]) begin
                    ez[i] = p[0]; eerr[i] = 1'b0; ezv[i] = 1'b1; n[i] = 0;
                end else if (chk_m[i] && n[i] == gl[i] + 1) begin
                    ez[i] = p[0]; eerr[i] = (w != p[0]); ezv[i] = 1'b1; n[i] = 0;
                    if (eerr[i] && ecnt[i] < cmax[i]) ecnt[i]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("z_g3",       8'(z3),    8'(ez[0]));
        check("z_valid_g3", 8'(zv3),   8'(ezv[0]));
        check("err_g3",     8'(err3),  8'(eerr[0]));
        check("err_cnt_g3", 8'(ec3),   8'(ecnt[0]));
        check("busy_g3",    8'(busy3), 8'(n[0] != 0));
        check("z_g1",       8'(z1),    8'(ez[1]));
        check("z_valid_g1", 8'(zv1),   8'(ezv[1]));
        check("err_g1",     8'(err1),  8'(eerr[1]));
        check("err_cnt_g1", 8'(ec1),   8'(ecnt[1]));
        check("busy_g1",    8'(busy1), 8'(n[1] != 0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input bit wb, input bit os, input bit ce);
        w_valid = v; w = wb; odd_sel = os; chk_en = ce;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic gap();
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_z_now", {5'd0, z3, zv3, err3}, 8'd0);
        w_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
    endtask

    int sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b1; w_valid = 1'b0; w = 1'b0; odd_sel = 1'b0; chk_en = 1'b0;
        model_reset();
        #12;
        compare_all();
        check("reset_busy", 8'(busy3), 8'd0);
        rst = 1'b0;

        // generate, even: 1,0,1 -> 0 ; 1,1,1 -> 1
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        check("gen_101_even", {5'd0, zv3, z3, err3}, 8'b100);
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        check("gen_111_even", {6'd0, zv3, z3}, 8'b11);
        gap();
        check("zv_one_cycle", 8'(zv3), 8'd0);

        // odd parity, odd_sel toggled after the first bit is ignored
        step(1, 1, 1, 0); step(1, 0, 0, 1); step(1, 1, 0, 1);
        check("gen_101_odd", {6'd0, zv3, z3}, 8'b11);

        // gaps with garbage on w
        step(1, 1, 0, 0); gap(); step(1, 0, 0, 0); gap(); gap(); step(1, 1, 0, 0);
        check("gap_group", {6'd0, zv3, z3}, 8'b10);
        // back-to-back groups
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
        check("b2b_a", {6'd0, zv3, z3}, 8'b10);
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        check("b2b_b", {6'd0, zv3, z3}, 8'b11);

        // check mode, even
        step(1, 1, 0, 1); step(1, 1, 0, 0); step(1, 0, 0, 0);
        check("chk_busy_wait", {6'd0, zv3, busy3}, 8'b01);
        step(1, 1, 0, 0);
        check("chk_mismatch", {4'd0, zv3, z3, err3, 1'b0}, 8'b1010);
        check("chk_cnt1", 8'(ec3), 8'd1);
        step(1, 1, 0, 1); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        check("chk_match", {6'd0, zv3, err3}, 8'b10);
        check("chk_cnt_hold", 8'(ec3), 8'd1);

        // saturation with ERR_W=2
        async_reset();
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 1);
            check("sat_cnt", 8'(ec3), 8'(sat_exp[k]));
        end

        // reset after 2 of 3 bits, then a fresh group
        step(1, 1, 0, 0); step(1, 0, 0, 0);
        async_reset();
        check("rst_no_zv", 8'(zv3), 8'd0);
        step(1, 1, 0, 0);
        check("post_rst_b1", 8'(zv3), 8'd0);
        step(1, 1, 0, 0);
        check("post_rst_b2", 8'(zv3), 8'd0);
        step(1, 0, 0, 0);
        check("post_rst_b3", {6'd0, zv3, z3}, 8'b10);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
